// File: rtl/inst_fetch.sv
// MiniMIPS32 instruction fetch: owns the PC and runs a req/ack fetch; 2 cycles per instruction plus 1 per bus wait.
// Backpressure: stall[0] holds the presented instruction; stallreq_if is raised while a fetch is outstanding.
module inst_fetch #(
   parameter logic [31:0]     RESET_PC = 32'hBFC0_0000,
   parameter int unsigned     EC_W     = 5,
   parameter logic [EC_W-1:0] EC_NONE  = 5'h1F,
   parameter logic [EC_W-1:0] EC_ADEL  = 5'h04
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [5:0]      stall,
   input  logic            flush,
   input  logic [31:0]     flush_pc,
   input  logic            branch_flag,
   input  logic [31:0]     branch_target,
   output logic            ibus_req,
   output logic [31:0]     ibus_addr,
   input  logic            ibus_ack,
   input  logic [31:0]     ibus_rdata,
   output logic            stallreq_if,
   output logic [31:0]     if_pc,
   output logic [31:0]     if_inst,
   output logic [EC_W-1:0] exc_code_o,
   output logic [31:0]     exc_badvaddr_o
);

   typedef enum logic [1:0] {S_BOOT, S_REQ, S_VALID, S_DROP} state_t;

   state_t          state_q, state_d;
   logic [31:0]     pc_q, pc_d;
   logic [31:0]     addr_q, addr_d;
   logic [31:0]     inst_q, inst_d;
   logic [EC_W-1:0] exc_q, exc_d;
   logic [31:0]     badv_q, badv_d;
   logic            pend_br_q, pend_br_d;
   logic [31:0]     pend_tgt_q, pend_tgt_d;
   logic            misalign;
   logic [31:0]     adv_pc;
   logic            unused_stall;

   assign unused_stall = ^stall[5:1];
   assign misalign     = (addr_q[1:0] != 2'b00);
   assign adv_pc       = pend_br_q   ? pend_tgt_q    :
                         branch_flag ? branch_target : addr_q + 32'd4;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_BOOT;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q       <= RESET_PC;
         addr_q     <= RESET_PC;
         inst_q     <= '0;
         exc_q      <= EC_NONE;
         badv_q     <= '0;
         pend_br_q  <= 1'b0;
         pend_tgt_q <= '0;
      end else begin
         pc_q       <= pc_d;
         addr_q     <= addr_d;
         inst_q     <= inst_d;
         exc_q      <= exc_d;
         badv_q     <= badv_d;
         pend_br_q  <= pend_br_d;
         pend_tgt_q <= pend_tgt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      addr_d     = addr_q;
      inst_d     = inst_q;
      exc_d      = exc_q;
      badv_d     = badv_q;
      pend_br_d  = pend_br_q;
      pend_tgt_d = pend_tgt_q;
      case (state_q)
         S_BOOT: begin
            state_d = S_REQ;
            if (flush) begin
               pc_d   = flush_pc;
               addr_d = flush_pc;
            end
         end
         S_REQ: begin
            if (branch_flag && !pend_br_q) begin
               pend_br_d  = 1'b1;
               pend_tgt_d = branch_target;
            end
            if (flush) begin
               pc_d = flush_pc;
               // A misaligned slot never issued a request, so there is no ack to wait for.
               if (misalign || ibus_ack) begin
                  addr_d  = flush_pc;
                  state_d = S_REQ;
               end else begin
                  state_d = S_DROP;
               end
            end else if (misalign) begin
               inst_d  = '0;
               exc_d   = EC_ADEL;
               badv_d  = addr_q;
               state_d = S_VALID;
            end else if (ibus_ack) begin
               inst_d  = ibus_rdata;
               exc_d   = EC_NONE;
               badv_d  = '0;
               state_d = S_VALID;
            end
         end
         S_VALID: begin
            if (flush) begin
               pc_d    = flush_pc;
               addr_d  = flush_pc;
               state_d = S_REQ;
            end else if (!stall[0]) begin
               pc_d      = adv_pc;
               addr_d    = adv_pc;
               pend_br_d = 1'b0;
               state_d   = S_REQ;
            end else if (branch_flag && !pend_br_q) begin
               pend_br_d  = 1'b1;
               pend_tgt_d = branch_target;
            end
         end
         S_DROP: begin
            if (flush) begin
               pc_d = flush_pc;
            end
            if (ibus_ack) begin
               addr_d  = flush ? flush_pc : pc_q;
               state_d = S_REQ;
            end
         end
         default: state_d = S_BOOT;
      endcase
      if (flush) begin
         pend_br_d = 1'b0;
      end
   end

   always_comb begin
      ibus_req       = 1'b0;
      stallreq_if    = 1'b0;
      ibus_addr      = '0;
      if_pc          = '0;
      if_inst        = '0;
      exc_code_o     = EC_NONE;
      exc_badvaddr_o = '0;
      if (!rst) begin
         ibus_addr = addr_q;
         if_pc     = addr_q;
         case (state_q)
            S_BOOT:  stallreq_if = 1'b1;
            S_REQ: begin
               ibus_req    = !misalign;
               stallreq_if = !misalign && !ibus_ack;
            end
            S_VALID: begin
               if_inst        = inst_q;
               exc_code_o     = exc_q;
               exc_badvaddr_o = badv_q;
            end
            S_DROP: begin
               ibus_req    = 1'b1;
               stallreq_if = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus a randomized run checked against an instruction-stream model.
module tb_inst_fetch;
   localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
   localparam logic [4:0]  EC_NONE  = 5'h1F;
   localparam logic [4:0]  EC_ADEL  = 5'h04;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [5:0]  stall = '0;
   logic        flush = 1'b0;
   logic [31:0] flush_pc = '0;
   logic        branch_flag = 1'b0;
   logic [31:0] branch_target = '0;
   logic        ibus_req;
   logic [31:0] ibus_addr;
   logic        ibus_ack = 1'b0;
   logic [31:0] ibus_rdata = '0;
   logic        stallreq_if;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic [4:0]  exc_code_o;
   logic [31:0] exc_badvaddr_o;

   int n_checks = 0;
   int n_fail   = 0;
   int ack_wait = 0;
   bit rand_wait = 0;
   int wait_cnt = 0;
   int cur_wait = 0;
   bit new_req  = 1;

   inst_fetch dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .flush_pc(flush_pc),
      .branch_flag(branch_flag), .branch_target(branch_target),
      .ibus_req(ibus_req), .ibus_addr(ibus_addr), .ibus_ack(ibus_ack), .ibus_rdata(ibus_rdata),
      .stallreq_if(stallreq_if), .if_pc(if_pc), .if_inst(if_inst),
      .exc_code_o(exc_code_o), .exc_badvaddr_o(exc_badvaddr_o)
   );

   always #5 clk = ~clk;

   // Memory contents are a pure function of the address and never zero.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] h;
      h = (a ^ 32'h5A5A_1234) * 32'h9E37_79B1;
      return h | 32'h1;
   endfunction

   // Bus slave: acks after a per-request number of wait cycles, garbage on rdata otherwise.
   always @(negedge clk) begin
      if (rst || ibus_req !== 1'b1) begin
         ibus_ack   = 1'b0;
         ibus_rdata = $urandom;
         wait_cnt   = 0;
         new_req    = 1;
      end else begin
         if (new_req) begin
            cur_wait = rand_wait ? int'($urandom_range(3, 0)) : ack_wait;
            new_req  = 0;
         end
         if (wait_cnt >= cur_wait) begin
            ibus_ack   = 1'b1;
            ibus_rdata = mem_word(ibus_addr);
            wait_cnt   = 0;
            new_req    = 1;
         end else begin
            ibus_ack   = 1'b0;
            ibus_rdata = $urandom;
            wait_cnt++;
         end
      end
   end

   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   function automatic bit presenting();
      return (if_inst !== 32'h0) || (exc_code_o !== EC_NONE);
   endfunction

   task automatic do_reset();
      flush = 0; branch_flag = 0; stall = '0; flush_pc = '0; branch_target = '0;
      rst = 1'b1;
      repeat (2) cyc();
      rst = 1'b0;
   endtask

   task automatic wait_ack(output logic [31:0] a, output bit ok);
      ok = 0; a = '0;
      for (int i = 0; i < 60 && !ok; i++) begin
         cyc();
         if (ibus_req === 1'b1 && ibus_ack === 1'b1) begin a = ibus_addr; ok = 1; end
      end
   endtask

   task automatic wait_present(output logic [31:0] pc, output bit ok);
      ok = 0; pc = '0;
      for (int i = 0; i < 60 && !ok; i++) begin
         cyc();
         if (presenting()) begin pc = if_pc; ok = 1; end
      end
   endtask

   task automatic wait_present_at(input logic [31:0] a, output bit ok);
      ok = 0;
      for (int i = 0; i < 60 && !ok; i++) begin
         cyc();
         if (presenting() && if_pc === a) ok = 1;
      end
   endtask

   task automatic wait_req_new(input logic [31:0] a, output bit ok);
      ok = 0;
      for (int i = 0; i < 60 && !ok; i++) begin
         cyc();
         if (ibus_req === 1'b1 && ibus_ack === 1'b0 && ibus_addr === a) ok = 1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cyc(); cyc();
      n_checks++;
      if ({ibus_req, stallreq_if, ibus_addr, if_pc, if_inst, exc_code_o, exc_badvaddr_o} !==
          {1'b0, 1'b0, 32'h0, 32'h0, 32'h0, EC_NONE, 32'h0}) begin
         n_fail++;
         $display("FAIL reset_outputs got req=%b sreq=%b addr=%h pc=%h inst=%h exc=%h bad=%h want all 0 exc=1f",
                  ibus_req, stallreq_if, ibus_addr, if_pc, if_inst, exc_code_o, exc_badvaddr_o);
      end
      ack_wait = 0;
      rst = 1'b0;
      cyc();
      n_checks++;
      if (ibus_req !== 1'b1 || ibus_addr !== RESET_PC) begin
         n_fail++;
         $display("FAIL first_request got req=%b addr=%h want req=1 addr=%h", ibus_req, ibus_addr, RESET_PC);
      end
   endtask

   task automatic test_zero_wait();
      logic [31:0] addrs[$];
      int          ack_cyc[$];
      logic [31:0] last_rd;
      bit          had_ack;
      do_reset();
      ack_wait = 0;
      had_ack = 0; last_rd = '0;
      for (int c = 0; c < 8; c++) begin
         cyc();
         if (had_ack) begin
            n_checks++;
            if (if_inst !== last_rd || stallreq_if !== 1'b0 || if_pc !== addrs[addrs.size()-1]) begin
               n_fail++;
               $display("FAIL zero_wait_valid got pc=%h inst=%h sreq=%b want pc=%h inst=%h sreq=0",
                        if_pc, if_inst, stallreq_if, addrs[addrs.size()-1], last_rd);
            end
         end
         had_ack = 0;
         if (ibus_req === 1'b1 && ibus_ack === 1'b1) begin
            addrs.push_back(ibus_addr); ack_cyc.push_back(c); last_rd = ibus_rdata; had_ack = 1;
         end
      end
      n_checks++;
      if (addrs.size() != 4) begin
         n_fail++;
         $display("FAIL zero_wait_count got %0d fetches want 4", addrs.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (addrs[i] !== RESET_PC + 32'(4 * i)) begin
               n_fail++;
               $display("FAIL zero_wait_addr%0d got %h want %h", i, addrs[i], RESET_PC + 32'(4 * i));
            end
         end
         n_checks++;
         if (ack_cyc[1] - ack_cyc[0] != 2) begin
            n_fail++;
            $display("FAIL zero_wait_cadence got %0d cycles want 2", ack_cyc[1] - ack_cyc[0]);
         end
      end
   endtask

   task automatic test_wait_states();
      do_reset();
      ack_wait = 3;
      for (int c = 0; c < 3; c++) begin
         cyc();
         n_checks++;
         if ({ibus_req, stallreq_if, ibus_addr, if_inst} !== {1'b1, 1'b1, RESET_PC, 32'h0}) begin
            n_fail++;
            $display("FAIL wait_hold%0d got req=%b sreq=%b addr=%h inst=%h want 1 1 %h 0",
                     c, ibus_req, stallreq_if, ibus_addr, if_inst, RESET_PC);
         end
      end
      cyc();
      n_checks++;
      if (ibus_ack !== 1'b1 || stallreq_if !== 1'b0 || ibus_req !== 1'b1) begin
         n_fail++;
         $display("FAIL wait_ack_cycle got ack=%b sreq=%b req=%b want 1 0 1", ibus_ack, stallreq_if, ibus_req);
      end
      cyc();
      n_checks++;
      if ({if_pc, if_inst, exc_code_o} !== {RESET_PC, mem_word(RESET_PC), EC_NONE}) begin
         n_fail++;
         $display("FAIL wait_valid got pc=%h inst=%h exc=%h want %h %h 1f",
                  if_pc, if_inst, exc_code_o, RESET_PC, mem_word(RESET_PC));
      end
      ack_wait = 0;
   endtask

   task automatic test_branch();
      logic [31:0] a, pc;
      bit ok;
      do_reset();
      ack_wait = 1;
      wait_present_at(32'hBFC0_0004, ok);
      branch_flag = 1; branch_target = 32'h8000_0100;
      cyc();
      branch_flag = 0;
      n_checks++;
      if (!ok || ibus_req !== 1'b1 || ibus_addr !== 32'h8000_0100) begin
         n_fail++;
         $display("FAIL branch_valid got ok=%b req=%b addr=%h want 1 1 80000100", ok, ibus_req, ibus_addr);
      end
      wait_req_new(32'h8000_0104, ok);
      branch_flag = 1; branch_target = 32'h8000_0200;
      cyc();
      branch_flag = 0;
      wait_present(pc, ok);
      n_checks++;
      if (!ok || pc !== 32'h8000_0104 || if_inst !== mem_word(32'h8000_0104)) begin
         n_fail++;
         $display("FAIL branch_delay_slot got pc=%h inst=%h want 80000104 %h", pc, if_inst, mem_word(32'h8000_0104));
      end
      wait_ack(a, ok);
      n_checks++;
      if (!ok || a !== 32'h8000_0200) begin
         n_fail++;
         $display("FAIL branch_pending got %h want 80000200", a);
      end
      wait_present_at(32'h8000_0200, ok);
      flush = 1; flush_pc = 32'hBFC0_0500; branch_flag = 1; branch_target = 32'h8000_0300;
      cyc();
      flush = 0; branch_flag = 0;
      wait_ack(a, ok);
      n_checks++;
      if (!ok || a !== 32'hBFC0_0500) begin
         n_fail++;
         $display("FAIL flush_beats_branch got %h want bfc00500", a);
      end
      wait_ack(a, ok);
      n_checks++;
      if (!ok || a !== 32'hBFC0_0504) begin
         n_fail++;
         $display("FAIL pend_cleared_by_flush got %h want bfc00504", a);
      end
      ack_wait = 0;
   endtask

   task automatic test_flush_drop();
      logic [31:0] a, pc;
      bit ok, ok2;
      do_reset();
      ack_wait = 0;
      wait_present_at(32'hBFC0_000C, ok);
      ack_wait = 4;
      wait_req_new(32'hBFC0_0010, ok2);
      flush = 1; flush_pc = 32'hBFC0_0380;
      cyc();
      flush = 0;
      n_checks++;
      if (!ok || !ok2 || {ibus_req, stallreq_if, ibus_addr, if_inst} !== {1'b1, 1'b1, 32'hBFC0_0010, 32'h0}) begin
         n_fail++;
         $display("FAIL drop_hold got req=%b sreq=%b addr=%h inst=%h want 1 1 bfc00010 0",
                  ibus_req, stallreq_if, ibus_addr, if_inst);
      end
      ack_wait = 0;
      wait_ack(a, ok);
      n_checks++;
      if (!ok || a !== 32'hBFC0_0010) begin
         n_fail++;
         $display("FAIL drop_ack_addr got %h want bfc00010", a);
      end
      wait_present(pc, ok);
      n_checks++;
      if (!ok || pc !== 32'hBFC0_0380 || if_inst !== mem_word(32'hBFC0_0380)) begin
         n_fail++;
         $display("FAIL drop_redirect got pc=%h inst=%h want bfc00380 %h", pc, if_inst, mem_word(32'hBFC0_0380));
      end
   endtask

   task automatic test_misaligned();
      bit ok;
      do_reset();
      ack_wait = 0;
      wait_present_at(RESET_PC, ok);
      flush = 1; flush_pc = 32'h8000_0002;
      cyc();
      flush = 0;
      n_checks++;
      if (!ok || ibus_req !== 1'b0 || stallreq_if !== 1'b0 || if_inst !== 32'h0) begin
         n_fail++;
         $display("FAIL adel_no_req got req=%b sreq=%b inst=%h want 0 0 0", ibus_req, stallreq_if, if_inst);
      end
      cyc();
      n_checks++;
      if ({if_pc, if_inst, exc_code_o, exc_badvaddr_o} !== {32'h8000_0002, 32'h0, EC_ADEL, 32'h8000_0002}) begin
         n_fail++;
         $display("FAIL adel_valid got pc=%h inst=%h exc=%h bad=%h want 80000002 0 04 80000002",
                  if_pc, if_inst, exc_code_o, exc_badvaddr_o);
      end
   endtask

   task automatic test_stall();
      logic [31:0] s_pc, s_inst, s_bad;
      logic [4:0]  s_exc;
      bit ok;
      do_reset();
      ack_wait = 0;
      wait_present_at(RESET_PC, ok);
      s_pc = RESET_PC; s_inst = mem_word(RESET_PC); s_exc = EC_NONE; s_bad = 32'h0;
      stall = 6'h01;
      for (int c = 0; c < 4; c++) begin
         cyc();
         n_checks++;
         if (!ok || {if_pc, if_inst, exc_code_o, exc_badvaddr_o, ibus_req} !== {s_pc, s_inst, s_exc, s_bad, 1'b0}) begin
            n_fail++;
            $display("FAIL stall_hold%0d got pc=%h inst=%h exc=%h req=%b want %h %h 1f 0",
                     c, if_pc, if_inst, exc_code_o, ibus_req, s_pc, s_inst);
         end
      end
      flush = 1; flush_pc = 32'hBFC0_0200;
      cyc();
      flush = 0; stall = '0;
      n_checks++;
      if (ibus_req !== 1'b1 || ibus_addr !== 32'hBFC0_0200) begin
         n_fail++;
         $display("FAIL stall_flush got req=%b addr=%h want 1 bfc00200", ibus_req, ibus_addr);
      end
      wait_present_at(32'hBFC0_0200, ok);
      stall = 6'h01;
      cyc();
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (!ok || {ibus_req, stallreq_if, ibus_addr, if_pc, if_inst, exc_code_o, exc_badvaddr_o} !==
          {1'b0, 1'b0, 32'h0, 32'h0, 32'h0, EC_NONE, 32'h0}) begin
         n_fail++;
         $display("FAIL async_reset got req=%b sreq=%b addr=%h pc=%h inst=%h exc=%h want all 0 exc=1f",
                  ibus_req, stallreq_if, ibus_addr, if_pc, if_inst, exc_code_o);
      end
      cyc();
      stall = '0;
      rst = 1'b0;
   endtask

   task automatic test_random();
      logic [31:0] cur, rd_t, exp_inst, exp_bad, prev_addr, r, rb;
      logic [4:0]  exp_exc;
      bit          rd_v, pres, prev_pend, fl, br, st;
      int          idle, n_pres;
      do_reset();
      rand_wait = 1;
      cur = RESET_PC; rd_v = 0; rd_t = '0; prev_pend = 0; prev_addr = '0; idle = 0; n_pres = 0;
      for (int c = 0; c < 3000; c++) begin
         cyc();
         pres = presenting();
         if (prev_pend) begin
            n_checks++;
            if (ibus_req !== 1'b1 || ibus_addr !== prev_addr) begin
               n_fail++;
               $display("FAIL rnd_req_stable c=%0d got req=%b addr=%h want 1 %h", c, ibus_req, ibus_addr, prev_addr);
            end
         end
         if (ibus_req === 1'b1) begin
            n_checks++;
            if (ibus_addr[1:0] !== 2'b00) begin
               n_fail++;
               $display("FAIL rnd_req_aligned c=%0d got addr=%h want low bits 0", c, ibus_addr);
            end
         end
         prev_pend = (ibus_req === 1'b1) && (ibus_ack !== 1'b1);
         prev_addr = ibus_addr;
         if (pres) begin
            idle = 0; n_pres++;
            exp_inst = (cur[1:0] == 2'b00) ? mem_word(cur) : 32'h0;
            exp_exc  = (cur[1:0] == 2'b00) ? EC_NONE : EC_ADEL;
            exp_bad  = (cur[1:0] == 2'b00) ? 32'h0 : cur;
            n_checks++;
            if ({if_pc, if_inst, exc_code_o, exc_badvaddr_o} !== {cur, exp_inst, exp_exc, exp_bad}) begin
               n_fail++;
               $display("FAIL rnd_present c=%0d got pc=%h inst=%h exc=%h bad=%h want %h %h %h %h",
                        c, if_pc, if_inst, exc_code_o, exc_badvaddr_o, cur, exp_inst, exp_exc, exp_bad);
            end
         end else begin
            idle++;
            n_checks++;
            if (exc_badvaddr_o !== 32'h0) begin
               n_fail++;
               $display("FAIL rnd_bubble c=%0d got bad=%h want 0", c, exc_badvaddr_o);
            end
            if (idle > 100) begin
               n_fail++;
               $display("FAIL rnd_liveness c=%0d got no instruction for %0d cycles want fewer", c, idle);
               break;
            end
         end
         fl = ($urandom_range(31, 0) == 0);
         br = pres && ($urandom_range(3, 0) == 0);
         st = ($urandom_range(2, 0) == 0);
         r  = $urandom;
         rb = $urandom;
         flush         = fl;
         flush_pc      = {r[31:2], ($urandom_range(4, 0) == 0) ? r[1:0] : 2'b00};
         branch_flag   = br;
         branch_target = {rb[31:2], 2'b00};
         stall         = {5'($urandom_range(31, 0)), st};
         // Instruction-stream view: the branch names the instruction after the current one.
         if (fl) begin
            cur = flush_pc; rd_v = 0;
         end else if (pres && !st) begin
            cur  = rd_v ? rd_t : (br ? branch_target : cur + 32'd4);
            rd_v = 0;
         end else if (pres && br && !rd_v) begin
            rd_v = 1; rd_t = branch_target;
         end
      end
      flush = 0; branch_flag = 0; stall = '0;
      rand_wait = 0;
      n_checks++;
      if (n_pres < 200) begin
         n_fail++;
         $display("FAIL rnd_throughput got %0d instructions want at least 200", n_pres);
      end
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_wait_states();
      test_branch();
      test_flush_drop();
      test_misaligned();
      test_stall();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout got no finish want finish before 2ms");
      $fatal(1, "timeout");
   end

endmodule
